// File: rtl/uart_cmd_frame_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_frame_if
//  Brief    : Byte-stream input and register-bank output bundle of the
//             UART command frame parser.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_cmd_frame_if #(
   parameter int DATA_BYTES = 1,
   parameter int NUM_REGS   = 4
);
   localparam int DW = 8 * DATA_BYTES;
   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [7:0]             rx_data;
   logic                   rx_done;
   logic [NUM_REGS*DW-1:0] ctrl_bus;
   logic                   cmd_valid;
   logic [AW-1:0]          cmd_addr;
   logic                   frame_err;
   logic [1:0]             err_code;
   logic                   busy;

   // Byte producer side (UART receiver / test driver)
   modport master (
      output rx_data, rx_done,
      input  ctrl_bus, cmd_valid, cmd_addr, frame_err, err_code, busy
   );

   // Parser side
   modport slave (
      input  rx_data, rx_done,
      output ctrl_bus, cmd_valid, cmd_addr, frame_err, err_code, busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_frame.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_frame
//  Brief    : Parses HDR0 HDR1 ADDR DATA[..] CHK TAIL byte frames into
//             addressed writes of a bank of control registers, with checksum,
//             address range check, inter-byte timeout and error reporting.
//  Revision : 1.0  initial release
// ============================================================================
module uart_cmd_frame #(
   parameter int         DATA_BYTES  = 1,
   parameter int         NUM_REGS    = 4,
   parameter logic [7:0] HDR0        = 8'hAA,
   parameter logic [7:0] HDR1        = 8'hA5,
   parameter logic [7:0] TAIL        = 8'hFF,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  wire logic       clk,
   input  wire logic       reset,
   uart_cmd_frame_if.slave bus
);
   localparam int DW  = 8 * DATA_BYTES;
   localparam int AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CW  = $clog2(TIMEOUT_CYC + 1);
   localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

   localparam logic [CW-1:0]  TO_LIM     = CW'(TIMEOUT_CYC);
   localparam logic [BCW-1:0] LAST_BYTE  = BCW'(DATA_BYTES - 1);
   localparam logic [7:0]     NUM_REGS_8 = 8'(NUM_REGS);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_H1   = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_CHK  = 3'd4;
   localparam logic [2:0] S_TL   = 3'd5;

   logic [2:0]     r_state;
   logic [2:0]     w_state_nxt;
   logic           r_rx_prev;
   logic           w_accept;
   logic           w_timeout;
   logic [7:0]     r_addr;
   logic [DW-1:0]  r_payload;
   logic [7:0]     r_sum;
   logic [BCW-1:0] r_byte_cnt;
   logic           r_chk_ok;
   logic [CW-1:0]  r_idle_cnt;
   logic [DW-1:0]  r_regs [NUM_REGS];
   logic           w_write;
   logic           w_err;
   logic [1:0]     w_err_code;
   logic           r_cmd_valid;
   logic [AW-1:0]  r_cmd_addr;
   logic           r_frame_err;
   logic [1:0]     r_err_code;

   // A byte counts only on the rising edge of rx_done, however long it is held
   assign w_accept  = bus.rx_done & ~r_rx_prev;
   // Timeout loses to a byte accepted in the same cycle
   assign w_timeout = (r_state != S_IDLE) && !w_accept && (r_idle_cnt == TO_LIM);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state: every transition is driven by an accepted byte, except timeout
   always_comb begin
      w_state_nxt = r_state;
      if (w_timeout) begin
         w_state_nxt = S_IDLE;
      end else if (w_accept) begin
         case (r_state)
            S_IDLE: if (bus.rx_data == HDR0) w_state_nxt = S_H1;
            S_H1: begin
               if (bus.rx_data == HDR1)      w_state_nxt = S_ADDR;
               else if (bus.rx_data != HDR0) w_state_nxt = S_IDLE;
            end
            S_ADDR: w_state_nxt = S_DATA;
            S_DATA: if (r_byte_cnt == LAST_BYTE) w_state_nxt = S_CHK;
            S_CHK:  w_state_nxt = S_TL;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Frame verdict on the tail byte, or a timeout anywhere inside a frame
   always_comb begin
      w_write    = 1'b0;
      w_err      = 1'b0;
      w_err_code = 2'd0;
      if (w_timeout) begin
         w_err      = 1'b1;
         w_err_code = 2'd3;
      end else if (w_accept && r_state == S_TL) begin
         if (bus.rx_data != TAIL) begin
            w_err      = 1'b1;
            w_err_code = 2'd0;
         end else if (!r_chk_ok) begin
            w_err      = 1'b1;
            w_err_code = 2'd1;
         end else if (r_addr >= NUM_REGS_8) begin
            w_err      = 1'b1;
            w_err_code = 2'd2;
         end else begin
            w_write    = 1'b1;
         end
      end
   end

   // Frame datapath: address, MSB-first payload shift, running checksum, timers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_prev  <= 1'b0;
         r_addr     <= 8'd0;
         r_payload  <= '0;
         r_sum      <= 8'd0;
         r_byte_cnt <= '0;
         r_chk_ok   <= 1'b0;
         r_idle_cnt <= '0;
      end else begin
         r_rx_prev <= bus.rx_done;
         if (w_accept || r_state == S_IDLE) r_idle_cnt <= '0;
         else                               r_idle_cnt <= r_idle_cnt + 1'b1;
         if (w_accept) begin
            case (r_state)
               S_ADDR: begin
                  r_addr     <= bus.rx_data;
                  r_sum      <= bus.rx_data;
                  r_byte_cnt <= '0;
               end
               S_DATA: begin
                  r_payload  <= DW'({r_payload, bus.rx_data});
                  r_sum      <= r_sum + bus.rx_data;
                  r_byte_cnt <= r_byte_cnt + 1'b1;
               end
               S_CHK:   r_chk_ok <= (bus.rx_data == r_sum);
               default: ;
            endcase
         end
      end
   end

   // Register bank: only the addressed register changes on a good frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_write) begin
         for (int i = 0; i < NUM_REGS; i++)
            if (r_addr == 8'(i)) r_regs[i] <= r_payload;
      end
   end

   // Registered result pulses; err_code and cmd_addr hold until the next event
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cmd_valid <= 1'b0;
         r_cmd_addr  <= '0;
         r_frame_err <= 1'b0;
         r_err_code  <= 2'd0;
      end else begin
         r_cmd_valid <= w_write;
         r_frame_err <= w_err;
         if (w_write) r_cmd_addr <= r_addr[AW-1:0];
         if (w_err)   r_err_code <= w_err_code;
      end
   end

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_pack
         assign bus.ctrl_bus[i*DW +: DW] = r_regs[i];
      end
   endgenerate

   assign bus.cmd_valid = r_cmd_valid;
   assign bus.cmd_addr  = r_cmd_addr;
   assign bus.frame_err = r_frame_err;
   assign bus.err_code  = r_err_code;
   assign bus.busy      = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_frame.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_cmd_frame
//  Brief    : Scoreboard bench for uart_cmd_frame (2-byte payload, 4 regs).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_frame;
   localparam int DB = 2;
   localparam int NR = 4;
   localparam int TO = 40;

   typedef struct {
      bit         is_err;
      logic [1:0] code;
      logic [7:0] addr;
      logic [15:0] data;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   exp_t exp_q[$];
   logic [15:0] m_regs [NR];
   exp_t m_e;

   uart_cmd_frame_if #(.DATA_BYTES(DB), .NUM_REGS(NR)) u_if ();

   uart_cmd_frame #(
      .DATA_BYTES(DB), .NUM_REGS(NR), .HDR0(8'hAA), .HDR1(8'hA5),
      .TAIL(8'hFF), .TIMEOUT_CYC(TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_bus();
      logic [63:0] p;
      p = '0;
      for (int i = 0; i < NR; i++) p[i*16 +: 16] = m_regs[i];
      return p;
   endfunction

   // Reference verdict for a frame, straight from the frame rules
   function automatic exp_t predict(input logic [7:0] a, input logic [15:0] d,
                                    input logic [7:0] c, input logic [7:0] t);
      exp_t p;
      logic [7:0] s;
      s = a + d[15:8] + d[7:0];
      p.addr = a; p.data = d; p.is_err = 1'b1; p.code = 2'd0;
      if (t != 8'hFF)          p.code = 2'd0;
      else if (c != s)         p.code = 2'd1;
      else if (int'(a) >= NR)  p.code = 2'd2;
      else                     p.is_err = 1'b0;
      return p;
   endfunction

   // Monitor: every output event pops one expectation
   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < NR; i++) m_regs[i] = '0;
      end else if (u_if.cmd_valid || u_if.frame_err) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {62'd0, u_if.cmd_valid, u_if.frame_err}, 64'd0);
         end else begin
            m_e = exp_q.pop_front();
            if (m_e.is_err) begin
               chk("err_pulse", {62'd0, u_if.cmd_valid, u_if.frame_err}, 64'd1);
               chk("err_code", 64'(u_if.err_code), 64'(m_e.code));
               chk("err_bus_hold", u_if.ctrl_bus, model_bus());
            end else begin
               chk("wr_pulse", {62'd0, u_if.cmd_valid, u_if.frame_err}, 64'd2);
               chk("wr_addr", 64'(u_if.cmd_addr), 64'(m_e.addr[1:0]));
               m_regs[m_e.addr[1:0]] = m_e.data;
               chk("wr_bus", u_if.ctrl_bus, model_bus());
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      u_if.rx_data = b;
      u_if.rx_done = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      u_if.rx_done = 1'b0;
      u_if.rx_data = 8'($urandom);
      repeat (gap) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input logic [7:0] c,
                             input logic [7:0] t, input int hold, input int gap);
      send_byte(8'hAA, hold, gap);
      send_byte(8'hA5, hold, gap);
      send_byte(a, hold, gap);
      send_byte(d[15:8], hold, gap);
      send_byte(d[7:0], hold, gap);
      send_byte(c, hold, gap);
      exp_q.push_back(predict(a, d, c, t));
      send_byte(t, hold, gap);
   endtask

   initial begin
      exp_t to_e;
      logic [7:0]  a, c, t;
      logic [15:0] d;
      int budget;
      checks = 0;
      errors = 0;
      reset = 1'b1;
      u_if.rx_data = 8'd0;
      u_if.rx_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bus", u_if.ctrl_bus, 64'd0);
      chk("rst_pulses", {62'd0, u_if.cmd_valid, u_if.frame_err}, 64'd0);
      chk("rst_code_addr", {60'd0, u_if.err_code, u_if.cmd_addr}, 64'd0);
      chk("rst_busy", 64'(u_if.busy), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed frames
      send_frame(8'h03, 16'h1234, 8'h49, 8'hFF, 1, 1);   // write reg3
      send_frame(8'h02, 16'h003C, 8'h3E, 8'hFF, 1, 2);   // write reg2
      send_frame(8'h01, 16'h0010, 8'h00, 8'hFF, 2, 1);   // bad checksum
      send_frame(8'h07, 16'h0001, 8'h08, 8'hFF, 1, 1);   // bad address
      send_frame(8'h04, 16'h0000, 8'h04, 8'hFF, 1, 1);   // first out-of-range address
      send_frame(8'h00, 16'h0055, 8'h55, 8'h00, 1, 1);   // bad tail
      send_frame(8'h00, 16'h0055, 8'h00, 8'h00, 1, 1);   // bad tail beats bad checksum
      send_frame(8'h07, 16'h0001, 8'h00, 8'hFF, 1, 1);   // bad checksum beats bad address
      // Resync on repeated header, rx_done held 5 cycles per byte
      send_byte(8'hAA, 5, 2);
      send_frame(8'h01, 16'h0F00, 8'h10, 8'hFF, 5, 2);
      // Aborted header then a good frame
      send_byte(8'hAA, 1, 1);
      send_byte(8'h12, 1, 1);
      send_frame(8'h00, 16'hBEEF, 8'hAD, 8'hFF, 1, 1);
      // Gaps just inside the timeout window
      send_frame(8'h02, 16'h5A5A, 8'hB6, 8'hFF, 1, TO - 6);

      // Timeout mid-frame, then a good frame
      send_byte(8'hAA, 1, 1);
      send_byte(8'hA5, 1, 1);
      to_e.is_err = 1'b1; to_e.code = 2'd3; to_e.addr = 8'd0; to_e.data = 16'd0;
      exp_q.push_back(to_e);
      send_byte(8'h00, 1, TO + 10);
      chk("timeout_busy", 64'(u_if.busy), 64'd0);
      send_frame(8'h03, 16'hC0DE, 8'hA1, 8'hFF, 1, 1);

      // Randomized frames
      for (int n = 0; n < 40; n++) begin
         a = 8'($urandom_range(0, 5));
         d = 16'($urandom);
         c = a + d[15:8] + d[7:0];
         t = 8'hFF;
         case ($urandom_range(0, 9))
            0: c = c ^ 8'($urandom_range(1, 255));
            1: t = 8'($urandom_range(0, 254));
            default: ;
         endcase
         send_frame(a, d, c, t, $urandom_range(1, 5), $urandom_range(1, 4));
      end

      budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin
         @(posedge clk); #1;
         budget++;
      end
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of the payload
      send_byte(8'hAA, 1, 1);
      send_byte(8'hA5, 1, 1);
      send_byte(8'h03, 1, 1);
      send_byte(8'h12, 1, 1);
      chk("busy_mid_frame", 64'(u_if.busy), 64'd1);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("async_rst_bus", u_if.ctrl_bus, 64'd0);
      chk("async_rst_busy", 64'(u_if.busy), 64'd0);
      chk("async_rst_out", {60'd0, u_if.cmd_valid, u_if.frame_err, u_if.err_code}, 64'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      send_byte(8'h34, 1, 1);
      send_byte(8'h49, 1, 1);
      send_byte(8'hFF, 1, 10);
      chk("post_rst_bus", u_if.ctrl_bus, 64'd0);
      chk("post_rst_busy", 64'(u_if.busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
